d16_alu: RTL and testbench
==========================

# d16_alu

16-bit arithmetic/logic unit of the dumb16 (d16) core datapath. It takes two 16-bit operands and a 3-bit operation code. It produces a registered 16-bit result with four condition flags (negative, overflow, zero, carry) for the core's flag register and branch logic. Operation codes are decoded by the d16 control unit.

## Interface
Parameters:
- none; data width is fixed at 16 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ctrl_alu  input  3  operation select (see Operation).
- a  input  16  operand A; value to shift for shift operations.
- b  input  16  operand B; shift amount for shift operations.
- s  output  16  registered result.
- n  output  1  negative flag, registered.
- o  output  1  signed-overflow flag, registered.
- z  output  1  zero flag, registered.
- c  output  1  carry/borrow/shift-out flag, registered.

## Operation
Opcodes (ctrl_alu):
- 000 NOP: s, n, o, z and c hold their previous values.
- 001 ADD: s = (a + b) mod 2^16.
  - c = carry out of bit 15.
  - o = 1 when a and b have the same sign and s differs from that sign.
- 010 SUB: s = (a − b) mod 2^16.
  - c = 1 on borrow (unsigned a < b).
  - o = 1 when a and b differ in sign and the sign of s differs from a.
- 011 LSH: logical left shift, s = a << b.
- 100 RSH: logical right shift, s = a >> b; zero fill, no sign extension.
- 101 AND, 110 OR, 111 XOR: bitwise operations, present only when the configuration macro is defined. Otherwise these codes behave as NOP.

Shift rules:
- Shift amount is the full unsigned value of b.
- b = 0: s = a, c = 0.
- 1 ≤ b ≤ 16: c = the last bit shifted out.
  - LSH: c = a[16−b].
  - RSH: c = a[b−1].
- b ≥ 17: s = 0, c = 0.

Flag rules for every non-NOP opcode:
- n = s[15].
- z = 1 exactly when s == 16'h0000.
- o = 0 for shifts and logic operations.
- c = 0 for logic operations.

## Timing
- Single-cycle latency: a, b and ctrl_alu are sampled on the rising edge of clk. The result and flags are valid after that edge and stay stable until the next update.
- No handshake. A new operation can be issued every cycle; back-to-back operations are fully pipelined at one per clock.
- Reset: when rst = 1 at a rising edge, s = 16'h0000, n = 0, o = 0, z = 1, c = 0.
- rst has priority over any opcode, including in the middle of an operation stream. The operation presented in the reset cycle is discarded.
- No combinational path from any input to any output.

## Configuration
- D16_ALU_LOGIC_EN defined: opcodes 101/110/111 perform AND/OR/XOR of a and b, with n and z updated and o = c = 0.
- D16_ALU_LOGIC_EN undefined: the logic datapath is not built, and opcodes 101–111 act as NOP (all outputs hold).

## Test plan
- Reset: assert rst for one edge → s = 0000, z = 1, n = o = c = 0. Then hold ctrl_alu = 000 for 3 cycles → outputs unchanged.
- ADD 0001 + 0001 → s = 0002, flags all 0.
- ADD 7FFF + 0001 → s = 8000, n = 1, o = 1, c = 0, z = 0.
- ADD FFFF + 0001 → s = 0000, z = 1, c = 1, o = 0.
- SUB:
  - 0001 − 0001 → s = 0000, z = 1, c = 0.
  - 0000 − 0001 → s = FFFF, n = 1, c = 1.
  - 8000 − 0001 → s = 7FFF, o = 1.
- Shifts:
  - LSH 0001 by 0001 → s = 0002, c = 0.
  - RSH 0001 by 0001 → s = 0000, z = 1, c = 1.
  - LSH 8001 by 0010 → s = 0000, c = 1 (b = 16).
  - RSH 8000 by 0014 → s = 0000, c = 0.
  - With D16_ALU_LOGIC_EN: F0F0 XOR FF00 → s = 0FF0. Without it: opcode 111 holds the previous outputs.

Source files
------------

// File: rtl/d16_alu.sv
// rtl/d16_alu.sv - dumb16 16-bit ALU with registered result and N/O/Z/C flags.
// Build with D16_ALU_LOGIC_EN defined to add AND/OR/XOR on opcodes 101/110/111.
module d16_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ctrl_alu,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s,
  output logic        n,
  output logic        o,
  output logic        z,
  output logic        c
);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_LSH = 3'b011;
  localparam logic [2:0] OP_RSH = 3'b100;
`ifdef D16_ALU_LOGIC_EN
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;
`endif

  logic [16:0] sum17;
  logic [16:0] diff17;
  logic [16:0] lsh17;
  logic [16:0] rsh17;
  logic        shift_zero;
  logic        shift_in_range;

  logic [15:0] res;
  logic        res_o;
  logic        res_c;
  logic        upd;

  assign sum17  = {1'b0, a} + {1'b0, b};
  assign diff17 = {1'b0, a} - {1'b0, b};

  // The extra 17th bit catches the last bit shifted out in either direction.
  assign lsh17 = {1'b0, a} << b[4:0];
  assign rsh17 = {a, 1'b0} >> b[4:0];

  assign shift_zero     = (b == 16'd0);
  assign shift_in_range = (b <= 16'd16);

  always_comb begin
    res   = 16'h0000;
    res_o = 1'b0;
    res_c = 1'b0;
    upd   = 1'b0;
    case (ctrl_alu)
      OP_ADD: begin
        upd   = 1'b1;
        res   = sum17[15:0];
        res_c = sum17[16];
        res_o = (a[15] == b[15]) && (sum17[15] != a[15]);
      end
      OP_SUB: begin
        upd   = 1'b1;
        res   = diff17[15:0];
        res_c = diff17[16];
        res_o = (a[15] != b[15]) && (diff17[15] != a[15]);
      end
      OP_LSH: begin
        upd = 1'b1;
        if (shift_zero) begin
          res = a;
        end else if (shift_in_range) begin
          res   = lsh17[15:0];
          res_c = lsh17[16];
        end
      end
      OP_RSH: begin
        upd = 1'b1;
        if (shift_zero) begin
          res = a;
        end else if (shift_in_range) begin
          res   = rsh17[16:1];
          res_c = rsh17[0];
        end
      end
`ifdef D16_ALU_LOGIC_EN
      OP_AND: begin
        upd = 1'b1;
        res = a & b;
      end
      OP_OR: begin
        upd = 1'b1;
        res = a | b;
      end
      OP_XOR: begin
        upd = 1'b1;
        res = a ^ b;
      end
`endif
      default: upd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= 16'h0000;
      n <= 1'b0;
      o <= 1'b0;
      z <= 1'b1;
      c <= 1'b0;
    end else if (upd) begin
      s <= res;
      n <= res[15];
      o <= res_o;
      z <= (res == 16'h0000);
      c <= res_c;
    end
  end

endmodule

// File: tb/tb_d16_alu.sv
// tb/tb_d16_alu.sv - directed self-checking bench for d16_alu.
// Opcode 111 expectation follows D16_ALU_LOGIC_EN.
module tb_d16_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  ctrl_alu;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] s;
  logic        n;
  logic        o;
  logic        z;
  logic        c;

  int checks;
  int errors;

  d16_alu dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl_alu (ctrl_alu),
    .a        (a),
    .b        (b),
    .s        (s),
    .n        (n),
    .o        (o),
    .z        (z),
    .c        (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, let it be sampled, then look at outputs 1 time unit later.
  task automatic step(input logic r, input logic [2:0] op, input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    rst      = r;
    ctrl_alu = op;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
  endtask

  // Expected vector packed as {s, n, o, z, c}.
  task automatic check(input string tag, input logic [19:0] exp_v);
    logic [19:0] obs;
    obs = {s, n, o, z, c};
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed s=%h n=%b o=%b z=%b c=%b expected s=%h n=%b o=%b z=%b c=%b",
             tag, obs[19:4], obs[3], obs[2], obs[1], obs[0],
             exp_v[19:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    ctrl_alu = 3'b000;
    a        = 16'h0000;
    b        = 16'h0000;

    step(1'b1, 3'b001, 16'h1234, 16'h1111);
    check("reset", {16'h0000, 4'b0010});

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b000, 16'hFFFF, 16'hFFFF);
      check("nop_after_reset", {16'h0000, 4'b0010});
    end

    step(1'b0, 3'b001, 16'h0001, 16'h0001);
    check("add_1_1", {16'h0002, 4'b0000});
    step(1'b0, 3'b001, 16'h7FFF, 16'h0001);
    check("add_ovf", {16'h8000, 4'b1100});
    step(1'b0, 3'b000, 16'h0000, 16'h0000);
    check("nop_hold", {16'h8000, 4'b1100});
    step(1'b0, 3'b001, 16'hFFFF, 16'h0001);
    check("add_carry", {16'h0000, 4'b0011});

    step(1'b0, 3'b010, 16'h0001, 16'h0001);
    check("sub_zero", {16'h0000, 4'b0010});
    step(1'b0, 3'b010, 16'h0000, 16'h0001);
    check("sub_borrow", {16'hFFFF, 4'b1001});
    step(1'b0, 3'b010, 16'h8000, 16'h0001);
    check("sub_ovf", {16'h7FFF, 4'b0100});

    step(1'b0, 3'b011, 16'h0001, 16'h0001);
    check("lsh_1", {16'h0002, 4'b0000});
    step(1'b0, 3'b100, 16'h0001, 16'h0001);
    check("rsh_out", {16'h0000, 4'b0011});
    step(1'b0, 3'b011, 16'h8001, 16'h0010);
    check("lsh_16", {16'h0000, 4'b0011});
    step(1'b0, 3'b100, 16'h8000, 16'h0014);
    check("rsh_20", {16'h0000, 4'b0010});
    step(1'b0, 3'b011, 16'h8000, 16'h0000);
    check("lsh_0", {16'h8000, 4'b1000});
    step(1'b0, 3'b011, 16'hFFFF, 16'h0011);
    check("lsh_17", {16'h0000, 4'b0010});
    step(1'b0, 3'b100, 16'h8000, 16'h000F);
    check("rsh_15", {16'h0001, 4'b0000});
    step(1'b0, 3'b100, 16'h8001, 16'h0001);
    check("rsh_1_carry", {16'h4000, 4'b0001});

    step(1'b0, 3'b111, 16'hF0F0, 16'hFF00);
`ifdef D16_ALU_LOGIC_EN
    check("xor", {16'h0FF0, 4'b0000});
`else
    check("op111_hold", {16'h4000, 4'b0001});
`endif

    step(1'b1, 3'b001, 16'h0001, 16'h0001);
    check("reset_midstream", {16'h0000, 4'b0010});
    step(1'b0, 3'b010, 16'h0003, 16'h0005);
    check("sub_after_reset", {16'hFFFE, 4'b1001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
